// File: rtl/sumador_serie_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The slave side is the adder; the master side is whoever issues operations.
interface sumador_serie_if #(
    parameter int ANCHO = 4
);
    logic             i_inicio;
    logic [ANCHO-1:0] i_operando_a;
    logic [ANCHO-1:0] i_operando_b;
    logic             o_ocupado;
    logic             o_listo;
    logic [ANCHO-1:0] o_suma;
    logic             o_acarreo;

    modport slave (
        input  i_inicio, i_operando_a, i_operando_b,
        output o_ocupado, o_listo, o_suma, o_acarreo
    );

    modport master (
        output i_inicio, i_operando_a, i_operando_b,
        input  o_ocupado, o_listo, o_suma, o_acarreo
    );
endinterface

// File: rtl/sumador_serie.sv
// Bit-serial adder: one full-adder step per clock, LSB first, carry held in a flop.
// Start/done handshake with a one-cycle o_listo pulse and registered result.
module sumador_serie #(
    parameter int ANCHO = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sumador_serie_if.slave   bus
);
    localparam int CW = $clog2(ANCHO + 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        LISTO   = 2'd2
    } estado_t;

    estado_t          r_estado;
    estado_t          w_estado_next;
    logic [ANCHO-1:0] r_a;
    logic [ANCHO-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [ANCHO-1:0] r_suma;
    logic             r_acarreo;

    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_s;
    logic             w_ha2_c;
    logic             w_c_next;
    logic             w_ultimo;
    logic             w_acepta;
    logic [ANCHO-1:0] w_a_next;

    // Full adder built from two half-adder cells plus an OR on the carries.
    assign w_ha1_s  = r_a[0] ^ r_b[0];
    assign w_ha1_c  = r_a[0] & r_b[0];
    assign w_s      = w_ha1_s ^ r_c;
    assign w_ha2_c  = w_ha1_s & r_c;
    assign w_c_next = w_ha1_c | w_ha2_c;

    assign w_ultimo = (r_cnt == CW'(ANCHO - 1));
    assign w_acepta = bus.i_inicio && ((r_estado == REPOSO) || (r_estado == LISTO));

    // Operand A shifts right and its vacated MSB collects the sum bits, so after
    // ANCHO steps the register holds the complete sum.
    for (genvar gi = 0; gi < ANCHO; gi++) begin : g_desplaza
        if (gi == ANCHO - 1) begin : g_msb
            assign w_a_next[gi] = w_s;
        end else begin : g_resto
            assign w_a_next[gi] = r_a[gi+1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            REPOSO:  if (w_acepta) w_estado_next = SUMANDO;
            SUMANDO: if (w_ultimo) w_estado_next = LISTO;
            LISTO:   w_estado_next = w_acepta ? SUMANDO : REPOSO;
            default: w_estado_next = REPOSO;
        endcase
    end

    always_comb begin
        bus.o_ocupado = (r_estado == SUMANDO);
        bus.o_listo   = (r_estado == LISTO);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_suma    <= '0;
            r_acarreo <= 1'b0;
        end else if (w_acepta) begin
            r_a   <= bus.i_operando_a;
            r_b   <= bus.i_operando_b;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (r_estado == SUMANDO) begin
            r_a   <= w_a_next;
            r_b   <= r_b >> 1;
            r_c   <= w_c_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_ultimo) begin
                r_suma    <= w_a_next;
                r_acarreo <= w_c_next;
            end
        end
    end

    assign bus.o_suma    = r_suma;
    assign bus.o_acarreo = r_acarreo;
endmodule

// File: tb/tb_sumador_serie.sv
// Scoreboard bench for sumador_serie at ANCHO=4 and ANCHO=1.
module tb_sumador_serie;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sumador_serie_if #(.ANCHO(4)) bus4();
    sumador_serie_if #(.ANCHO(1)) bus1();

    sumador_serie #(.ANCHO(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4.slave));
    sumador_serie #(.ANCHO(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int suma;
        int acarreo;
        int due;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4;
    exp_t e1;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results are compared when o_listo appears; an overdue entry counts as missing.
    always @(negedge clk) begin
        if (bus4.o_listo) begin
            if (q4.size() == 0) begin
                check("listo4_unexpected", bus4.o_listo, 0);
            end else begin
                e4 = q4.pop_front();
                $display("ancho4 result: suma=%0d acarreo=%0d cycle=%0d (exp %0d/%0d @%0d)",
                         bus4.o_suma, bus4.o_acarreo, cyc, e4.suma, e4.acarreo, e4.due);
                check("listo4_cycle", cyc, e4.due);
                check("suma4", bus4.o_suma, e4.suma);
                check("acarreo4", bus4.o_acarreo, e4.acarreo);
            end
        end else if (q4.size() > 0 && cyc >= q4[0].due) begin
            check("listo4_missing", bus4.o_listo, 1);
            void'(q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus1.o_listo) begin
            if (q1.size() == 0) begin
                check("listo1_unexpected", bus1.o_listo, 0);
            end else begin
                e1 = q1.pop_front();
                $display("ancho1 result: suma=%0d acarreo=%0d cycle=%0d (exp %0d/%0d @%0d)",
                         bus1.o_suma, bus1.o_acarreo, cyc, e1.suma, e1.acarreo, e1.due);
                check("listo1_cycle", cyc, e1.due);
                check("suma1", bus1.o_suma, e1.suma);
                check("acarreo1", bus1.o_acarreo, e1.acarreo);
            end
        end else if (q1.size() > 0 && cyc >= q1[0].due) begin
            check("listo1_missing", bus1.o_listo, 1);
            void'(q1.pop_front());
        end
    end

    // Drives a start for one cycle on the 4-bit adder and records the expectation.
    task automatic start4(input int a, input int b);
        exp_t e;
        bus4.i_operando_a = 4'(a);
        bus4.i_operando_b = 4'(b);
        bus4.i_inicio     = 1'b1;
        tick();
        e.suma    = (a + b) % 16;
        e.acarreo = (a + b) / 16;
        e.due     = cyc + 4;
        q4.push_back(e);
        bus4.i_inicio = 1'b0;
    endtask

    task automatic start1(input int a, input int b);
        exp_t e;
        bus1.i_operando_a = 1'(a);
        bus1.i_operando_b = 1'(b);
        bus1.i_inicio     = 1'b1;
        tick();
        e.suma    = (a + b) % 2;
        e.acarreo = (a + b) / 2;
        e.due     = cyc + 1;
        q1.push_back(e);
        bus1.i_inicio = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        bus4.i_inicio = 1'b0; bus4.i_operando_a = '0; bus4.i_operando_b = '0;
        bus1.i_inicio = 1'b0; bus1.i_operando_a = '0; bus1.i_operando_b = '0;
        repeat (2) tick();
        check("rst_ocupado4", bus4.o_ocupado, 0);
        check("rst_listo4", bus4.o_listo, 0);
        check("rst_suma4", bus4.o_suma, 0);
        check("rst_acarreo4", bus4.o_acarreo, 0);
        check("rst_listo1", bus1.o_listo, 0);
        rst = 1'b0;
        tick();

        // 3 + 5: busy for exactly four cycles, then result holds.
        start4(3, 5);
        for (int i = 0; i < 3; i++) begin
            check("ocupado4_busy", bus4.o_ocupado, 1);
            tick();
        end
        check("ocupado4_busy", bus4.o_ocupado, 1);
        tick();
        check("ocupado4_in_listo", bus4.o_ocupado, 0);
        repeat (3) tick();
        check("suma4_hold", bus4.o_suma, 8);
        check("ocupado4_idle", bus4.o_ocupado, 0);

        // Corner operands.
        start4(15, 1);  repeat (6) tick();
        start4(15, 15); repeat (6) tick();
        start4(0, 0);   repeat (6) tick();

        // A start request mid-operation is ignored.
        start4(6, 7);
        tick();
        bus4.i_operando_a = 4'd1; bus4.i_operando_b = 4'd1; bus4.i_inicio = 1'b1;
        tick();
        bus4.i_inicio = 1'b0;
        repeat (5) tick();
        check("ignore_suma4", bus4.o_suma, 13);

        // Reset mid-operation discards the sum and produces no pulse.
        start4(9, 9);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_suma4", bus4.o_suma, 0);
        check("midrst_acarreo4", bus4.o_acarreo, 0);
        check("midrst_ocupado4", bus4.o_ocupado, 0);
        check("midrst_listo4", bus4.o_listo, 0);
        q4.delete(q4.size() - 1);
        rst = 1'b0;
        repeat (6) tick();
        start4(2, 2); repeat (6) tick();

        // Back-to-back with i_inicio held high: pulses five cycles apart.
        bus4.i_operando_a = 4'd1; bus4.i_operando_b = 4'd2; bus4.i_inicio = 1'b1;
        tick();
        e.suma = 3; e.acarreo = 0; e.due = cyc + 4;
        q4.push_back(e);
        repeat (3) tick();
        bus4.i_operando_a = 4'd7; bus4.i_operando_b = 4'd8;
        tick();
        tick();
        e.suma = 15; e.acarreo = 0; e.due = cyc + 4;
        q4.push_back(e);
        bus4.i_inicio = 1'b0;
        repeat (6) tick();

        // ANCHO=1 exhaustive.
        for (int v = 0; v < 4; v++) begin
            start1(v / 2, v % 2);
            repeat (2) tick();
        end
        repeat (4) tick();

        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
